// File: rtl/sw_pe_affine.sv
`default_nettype none
// ============================================================================
// Module      : sw_pe_affine
// Description : Smith-Waterman systolic processing element with affine gaps.
//               Holds one query symbol, scores the streamed target column
//               against it (M and I matrices), and forwards scores, the
//               target symbol and the running high score with its column.
//               Two-stage pipeline, biased-unsigned saturating scores,
//               run-time local/global mode.
//               Optional traceback output enabled by macro SW_PE_TRACE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_pe_affine #(
    parameter int SCORE_WIDTH = 12,
    parameter int BASE_WIDTH  = 2,
    parameter int COL_WIDTH   = 16,
    parameter int ZERO        = 2**(SCORE_WIDTH-1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   query_ld,
    input  logic [BASE_WIDTH-1:0]  query_in,
    input  logic                   mode_global,
    input  logic                   en_in,
    input  logic [BASE_WIDTH-1:0]  data_in,
    input  logic [SCORE_WIDTH-1:0] M_in,
    input  logic [SCORE_WIDTH-1:0] I_in,
    input  logic [SCORE_WIDTH-1:0] High_in,
    input  logic [COL_WIDTH-1:0]   HighPos_in,
    input  logic [SCORE_WIDTH-1:0] match,
    input  logic [SCORE_WIDTH-1:0] mismatch,
    input  logic [SCORE_WIDTH-1:0] gap_open,
    input  logic [SCORE_WIDTH-1:0] gap_extend,
    output logic [BASE_WIDTH-1:0]  data_out,
    output logic [SCORE_WIDTH-1:0] M_out,
    output logic [SCORE_WIDTH-1:0] I_out,
    output logic [SCORE_WIDTH-1:0] High_out,
    output logic [COL_WIDTH-1:0]   HighPos_out,
    output logic                   en_out,
`ifdef SW_PE_TRACE_EN
    output logic [1:0]             tb_out,
`endif
    output logic                   vld
);

    localparam logic [SCORE_WIDTH-1:0] c_zero = SCORE_WIDTH'(ZERO);

    // ------------------------------------------------------------------
    // Helpers. Sums are formed two bits wider than a score so that a
    // biased score plus two negative penalties, or a full-scale score
    // plus a positive penalty, never wraps before saturation.
    // ------------------------------------------------------------------
    function automatic logic [SCORE_WIDTH-1:0] f_max(input logic [SCORE_WIDTH-1:0] a,
                                                     input logic [SCORE_WIDTH-1:0] b);
        return (b > a) ? b : a;
    endfunction

    function automatic logic signed [SCORE_WIDTH+1:0] f_ext_u(input logic [SCORE_WIDTH-1:0] a);
        return $signed({2'b00, a});
    endfunction

    function automatic logic signed [SCORE_WIDTH+1:0] f_ext_s(input logic [SCORE_WIDTH-1:0] p);
        return $signed({{2{p[SCORE_WIDTH-1]}}, p});
    endfunction

    // Clamp a wide signed sum into [0, 2**SCORE_WIDTH-1].
    function automatic logic [SCORE_WIDTH-1:0] f_sat(input logic signed [SCORE_WIDTH+1:0] v);
        if (v[SCORE_WIDTH+1]) begin
            return '0;
        end else if (v[SCORE_WIDTH]) begin
            return '1;
        end else begin
            return v[SCORE_WIDTH-1:0];
        end
    endfunction

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [BASE_WIDTH-1:0]  r_query;
    logic                   r_vld;
    logic [COL_WIDTH-1:0]   r_col;

    // Stage-1 registers
    logic                   r_en1;
    logic                   r_first1;
    logic [BASE_WIDTH-1:0]  r_data1;
    logic [COL_WIDTH-1:0]   r_col1;
    logic [SCORE_WIDTH-1:0] r_diag;
    logic [SCORE_WIDTH-1:0] r_open;
    logic [SCORE_WIDTH-1:0] r_ext;
    logic [SCORE_WIDTH-1:0] r_sub;
    logic [SCORE_WIDTH-1:0] r_hi1;
    logic [COL_WIDTH-1:0]   r_hipos1;
    logic [SCORE_WIDTH-1:0] r_m_diag;
    logic [SCORE_WIDTH-1:0] r_i_diag;
    logic [SCORE_WIDTH-1:0] r_m_up;
    logic [SCORE_WIDTH-1:0] r_i_up;

    // Stage-2 (output) registers
    logic                   r_en_out;
    logic                   r_en_out_q;
    logic [BASE_WIDTH-1:0]  r_data_out;
    logic [SCORE_WIDTH-1:0] r_m_out;
    logic [SCORE_WIDTH-1:0] r_i_out;
    logic [SCORE_WIDTH-1:0] r_high;
    logic [COL_WIDTH-1:0]   r_highpos;

`ifdef SW_PE_TRACE_EN
    logic                   r_diag_src1;
    logic [1:0]             r_trace;
`endif

    // ------------------------------------------------------------------
    // Stage-1 combinational terms
    // ------------------------------------------------------------------
    // A beat accepted while not already calculating opens a new stream;
    // all neighbourhood operands are replaced by the biased zero.
    logic                   w_first;
    logic [SCORE_WIDTH-1:0] w_m_left;
    logic [SCORE_WIDTH-1:0] w_i_left;
    logic [SCORE_WIDTH-1:0] w_m_up;
    logic [SCORE_WIDTH-1:0] w_i_up;
    logic [SCORE_WIDTH-1:0] w_diag;
    logic [SCORE_WIDTH-1:0] w_open;
    logic [SCORE_WIDTH-1:0] w_ext;
    logic [SCORE_WIDTH-1:0] w_sub;
    logic                   w_diag_from_i;

    assign w_first       = en_in && (r_state != S_CALC);
    assign w_m_left      = w_first ? c_zero : M_in;
    assign w_i_left      = w_first ? c_zero : I_in;
    assign w_m_up        = w_first ? c_zero : r_m_up;
    assign w_i_up        = w_first ? c_zero : r_i_up;
    assign w_diag_from_i = !w_first && (r_i_diag > r_m_diag);
    assign w_diag        = w_first ? c_zero : f_max(r_m_diag, r_i_diag);
    assign w_open        = f_sat(f_ext_u(f_max(w_m_left, w_m_up))
                                 + f_ext_s(gap_open) + f_ext_s(gap_extend));
    assign w_ext         = f_sat(f_ext_u(f_max(w_i_left, w_i_up)) + f_ext_s(gap_extend));
    assign w_sub         = (data_in == r_query) ? match : mismatch;

    // ------------------------------------------------------------------
    // Stage-2 combinational terms
    // ------------------------------------------------------------------
    logic [SCORE_WIDTH-1:0] w_m_raw;
    logic                   w_m_floor;
    logic [SCORE_WIDTH-1:0] w_m_new;
    logic [SCORE_WIDTH-1:0] w_i_new;
    logic [SCORE_WIDTH-1:0] w_cand;
    logic [SCORE_WIDTH-1:0] w_best;
    logic [COL_WIDTH-1:0]   w_best_pos;

    assign w_m_raw   = f_sat(f_ext_u(r_diag) + f_ext_s(r_sub));
    assign w_m_floor = !mode_global && (w_m_raw < c_zero);
    assign w_m_new   = w_m_floor ? c_zero : w_m_raw;
    assign w_i_new   = f_max(r_open, r_ext);
    assign w_cand    = f_max(w_m_new, w_i_new);

    // High-score selection: earlier value first, then left neighbour, then
    // this cell; strict compares so that ties keep the earlier column.
    always_comb begin
        w_best     = r_first1 ? r_hi1 : r_high;
        w_best_pos = r_first1 ? r_hipos1 : r_highpos;
        if (r_hi1 > w_best) begin
            w_best     = r_hi1;
            w_best_pos = r_hipos1;
        end
        if (w_cand > w_best) begin
            w_best     = w_cand;
            w_best_pos = r_col1;
        end
    end

    // Stream control FSM, query register and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_query <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (query_ld) begin
                        r_query <= query_in;
                    end
                    if (en_in) begin
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    // Finish once the last result has left the PE.
                    if (r_en_out_q && !r_en_out) begin
                        r_state <= S_DONE;
                        r_vld   <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (query_ld) begin
                        r_query <= query_in;
                    end
                    r_state <= en_in ? S_CALC : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stage 1: operand selection, gap terms, substitution score, column.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en1    <= 1'b0;
            r_first1 <= 1'b0;
            r_data1  <= '0;
            r_col1   <= '0;
            r_col    <= '0;
            r_diag   <= c_zero;
            r_open   <= c_zero;
            r_ext    <= c_zero;
            r_sub    <= '0;
            r_hi1    <= c_zero;
            r_hipos1 <= '0;
            r_m_diag <= c_zero;
            r_i_diag <= c_zero;
            r_m_up   <= c_zero;
            r_i_up   <= c_zero;
        end else begin
            r_en1 <= en_in;
            if (en_in) begin
                r_first1 <= w_first;
                r_data1  <= data_in;
                r_col1   <= w_first ? '0 : r_col;
                r_col    <= w_first ? COL_WIDTH'(1) : r_col + COL_WIDTH'(1);
                r_diag   <= w_diag;
                r_open   <= w_open;
                r_ext    <= w_ext;
                r_sub    <= w_sub;
                r_hi1    <= High_in;
                r_hipos1 <= HighPos_in;
                r_m_diag <= M_in;
                r_i_diag <= I_in;
                r_m_up   <= w_first ? c_zero : r_m_out;
                r_i_up   <= w_first ? c_zero : r_i_out;
            end
        end
    end

    // Stage 2: final M/I scores and running high score; hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en_out   <= 1'b0;
            r_en_out_q <= 1'b0;
            r_data_out <= '0;
            r_m_out    <= c_zero;
            r_i_out    <= c_zero;
            r_high     <= c_zero;
            r_highpos  <= '0;
        end else begin
            r_en_out   <= r_en1;
            r_en_out_q <= r_en_out;
            if (r_en1) begin
                r_data_out <= r_data1;
                r_m_out    <= w_m_new;
                r_i_out    <= w_i_new;
                r_high     <= w_best;
                r_highpos  <= w_best_pos;
            end
        end
    end

`ifdef SW_PE_TRACE_EN
    // Traceback code: 0 floored, 1 diagonal from M, 2 diagonal from I, 3 gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_diag_src1 <= 1'b0;
            r_trace     <= 2'd0;
        end else begin
            if (en_in) begin
                r_diag_src1 <= w_diag_from_i;
            end
            if (r_en1) begin
                if (w_m_floor) begin
                    r_trace <= 2'd0;
                end else if (w_i_new > w_m_new) begin
                    r_trace <= 2'd3;
                end else begin
                    r_trace <= r_diag_src1 ? 2'd2 : 2'd1;
                end
            end
        end
    end

    assign tb_out = r_trace;
`else
    // Diagonal source only feeds the traceback output.
    logic w_unused_trace;
    assign w_unused_trace = w_diag_from_i;
`endif

    assign data_out    = r_data_out;
    assign M_out       = r_m_out;
    assign I_out       = r_i_out;
    assign High_out    = r_high;
    assign HighPos_out = r_highpos;
    assign en_out      = r_en_out;
    assign vld         = r_vld;

endmodule
`default_nettype wire

// File: tb/tb_sw_pe_affine.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_pe_affine
// Description : Directed self-checking bench for sw_pe_affine with
//               hand-computed expected scores (match +2, mismatch -1,
//               gap_open -3, gap_extend -1, biased zero 2048).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_pe_affine;

    localparam int SW = 12;
    localparam int BW = 2;
    localparam int CW = 16;

    localparam logic [1:0] c_a = 2'd0;
    localparam logic [1:0] c_c = 2'd1;
    localparam logic [1:0] c_g = 2'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic          query_ld;
    logic [BW-1:0] query_in;
    logic          mode_global;
    logic          en_in;
    logic [BW-1:0] data_in;
    logic [SW-1:0] M_in, I_in, High_in;
    logic [CW-1:0] HighPos_in;
    logic [SW-1:0] match, mismatch, gap_open, gap_extend;
    logic [BW-1:0] data_out;
    logic [SW-1:0] M_out, I_out, High_out;
    logic [CW-1:0] HighPos_out;
    logic          en_out;
    logic          vld;

    int checks = 0;
    int errors = 0;

    sw_pe_affine #(
        .SCORE_WIDTH (SW),
        .BASE_WIDTH  (BW),
        .COL_WIDTH   (CW),
        .ZERO        (2048)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .query_ld    (query_ld),
        .query_in    (query_in),
        .mode_global (mode_global),
        .en_in       (en_in),
        .data_in     (data_in),
        .M_in        (M_in),
        .I_in        (I_in),
        .High_in     (High_in),
        .HighPos_in  (HighPos_in),
        .match       (match),
        .mismatch    (mismatch),
        .gap_open    (gap_open),
        .gap_extend  (gap_extend),
        .data_out    (data_out),
        .M_out       (M_out),
        .I_out       (I_out),
        .High_out    (High_out),
        .HighPos_out (HighPos_out),
        .en_out      (en_out),
        .vld         (vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one target beat for one clock.
    task automatic beat(input logic [1:0] d, input logic [11:0] m, input logic [11:0] i,
                        input logic [11:0] h);
        en_in      = 1'b1;
        data_in    = d;
        M_in       = m;
        I_in       = i;
        High_in    = h;
        HighPos_in = '0;
        tick();
    endtask

    // Let the stream run out through DONE back to IDLE.
    task automatic drain();
        en_in = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        query_ld    = 1'b0;
        query_in    = '0;
        mode_global = 1'b0;
        en_in       = 1'b0;
        data_in     = '0;
        M_in        = 12'd2048;
        I_in        = 12'd2048;
        High_in     = 12'd2048;
        HighPos_in  = '0;
        match       = 12'd2;
        mismatch    = 12'hFFF;
        gap_open    = 12'hFFD;
        gap_extend  = 12'hFFF;
        #2 rst = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_M",       32'(M_out),       2048);
        check("rst_I",       32'(I_out),       2048);
        check("rst_High",    32'(High_out),    2048);
        check("rst_HighPos", 32'(HighPos_out), 0);
        check("rst_data",    32'(data_out),    0);
        check("rst_en_out",  32'(en_out),      0);
        check("rst_vld",     32'(vld),         0);
        rst = 1'b1;
        tick();

        // Single match, query A
        query_ld = 1'b1;
        query_in = c_a;
        tick();
        query_ld = 1'b0;
        beat(c_a, 12'd2048, 12'd2048, 12'd2048);
        en_in = 1'b0;
        check("one_en_early", 32'(en_out), 0);
        tick();
        check("one_en",      32'(en_out),      1);
        check("one_M",       32'(M_out),       2050);
        check("one_I",       32'(I_out),       2047);
        check("one_High",    32'(High_out),    2050);
        check("one_HighPos", 32'(HighPos_out), 0);
        check("one_data",    32'(data_out),    0);
        check("one_vld_lo",  32'(vld),         0);
        tick();
        check("one_en_fall", 32'(en_out), 0);
        check("one_vld_lo2", 32'(vld),    0);
        tick();
        check("one_vld_hi",  32'(vld),    1);
        tick();
        check("one_vld_end", 32'(vld),    0);
        drain();

        // Mismatch, local floor then global
        beat(c_g, 12'd2048, 12'd2048, 12'd2048);
        en_in = 1'b0;
        tick();
        check("mis_loc_M",    32'(M_out),    2048);
        check("mis_loc_data", 32'(data_out), 2);
        drain();
        mode_global = 1'b1;
        beat(c_g, 12'd2048, 12'd2048, 12'd2048);
        en_in = 1'b0;
        tick();
        check("mis_glb_M",    32'(M_out),    2047);
        check("mis_glb_High", 32'(High_out), 2048);
        drain();

        // Upper saturation
        mode_global = 1'b0;
        beat(c_a, 12'd4095, 12'd2048, 12'd2048);
        beat(c_a, 12'd2048, 12'd2048, 12'd2048);
        check("sat_b1_M", 32'(M_out), 2050);
        en_in = 1'b0;
        tick();
        check("sat_hi_M",       32'(M_out),       4095);
        check("sat_hi_High",    32'(High_out),    4095);
        check("sat_hi_HighPos", 32'(HighPos_out), 1);
        drain();

        // Lower saturation, global mode
        mode_global = 1'b1;
        beat(c_a, 12'd1, 12'd0, 12'd2048);
        beat(c_g, 12'd2048, 12'd2048, 12'd2048);
        en_in = 1'b0;
        tick();
        check("sat_lo_M", 32'(M_out), 0);
        drain();
        mode_global = 1'b0;

        // Query load attempt during CALC is ignored
        beat(c_a, 12'd2048, 12'd2048, 12'd2048);
        query_ld = 1'b1;
        query_in = c_c;
        beat(c_a, 12'd2048, 12'd2048, 12'd2048);
        query_ld = 1'b0;
        beat(c_a, 12'd2048, 12'd2048, 12'd2048);
        en_in = 1'b0;
        tick();
        check("qprot_M",       32'(M_out),       2050);
        check("qprot_High",    32'(High_out),    2050);
        check("qprot_HighPos", 32'(HighPos_out), 0);
        drain();
        beat(c_a, 12'd2048, 12'd2048, 12'd2048);
        en_in = 1'b0;
        tick();
        check("qprot_after_M", 32'(M_out), 2050);
        drain();

        // Query load in IDLE takes effect: C vs A mismatches, floored
        query_ld = 1'b1;
        query_in = c_c;
        tick();
        query_ld = 1'b0;
        beat(c_a, 12'd2048, 12'd2048, 12'd2048);
        en_in = 1'b0;
        tick();
        check("qload_M", 32'(M_out), 2048);
        drain();
        query_ld = 1'b1;
        query_in = c_a;
        tick();
        query_ld = 1'b0;

        // Position tie: equal best scores at columns 1 and 3
        beat(c_g, 12'd2048, 12'd2048, 12'd2048);
        beat(c_a, 12'd2048, 12'd2048, 12'd2048);
        check("tie_c0_M", 32'(M_out), 2048);
        beat(c_g, 12'd2048, 12'd2048, 12'd2048);
        check("tie_c1_High",    32'(High_out),    2050);
        check("tie_c1_HighPos", 32'(HighPos_out), 1);
        beat(c_a, 12'd2048, 12'd2048, 12'd2048);
        check("tie_c2_M", 32'(M_out), 2048);
        en_in = 1'b0;
        tick();
        check("tie_c3_M",       32'(M_out),       2050);
        check("tie_c3_High",    32'(High_out),    2050);
        check("tie_c3_HighPos", 32'(HighPos_out), 1);
        drain();

        // Asynchronous reset mid-stream
        beat(c_a, 12'd2048, 12'd2048, 12'd2048);
        en_in = 1'b0;
        tick();
        check("arst_pre_en", 32'(en_out), 1);
        check("arst_pre_M",  32'(M_out),  2050);
        #2 rst = 1'b0;
        #1;
        check("arst_M",    32'(M_out),    2048);
        check("arst_High", 32'(High_out), 2048);
        check("arst_en",   32'(en_out),   0);
        check("arst_vld",  32'(vld),      0);
        tick();
        rst = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
